// File: rtl/beta_imem_arbiter.sv
// beta_imem_arbiter: two-requester round-robin arbiter for one instruction memory.
// Ports: m0_*/m1_* requester side (req/addr in, ready/valid/rdata out),
// imem_* memory side, busy_o/grant_o/timeout_o status. All outputs registered.
module beta_imem_arbiter #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m0_req_i,
  input  logic [AddrWidth-1:0] m0_addr_i,
  output logic                 m0_ready_o,
  output logic                 m0_valid_o,
  output logic [DataWidth-1:0] m0_rdata_o,
  input  logic                 m1_req_i,
  input  logic [AddrWidth-1:0] m1_addr_i,
  output logic                 m1_ready_o,
  output logic                 m1_valid_o,
  output logic [DataWidth-1:0] m1_rdata_o,
  output logic                 imem_req_o,
  output logic [AddrWidth-1:0] imem_addr_o,
  input  logic                 imem_ready_i,
  input  logic                 imem_valid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  output logic                 busy_o,
  output logic                 grant_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WRDY,
    ARB_WVLD
  } state_e;

  // Counter hits this value on the last cycle before an abort.
  localparam logic [7:0] Lim = 8'(TimeoutCycles - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic                 rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic                 vld0_q, vld0_d, vld1_q, vld1_d;
  logic [DataWidth-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic                 to_q, to_d;
  logic                 busy_q, busy_d;
  logic                 win;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    req_d   = req_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    last_d  = last_q;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
    vld0_d  = 1'b0;
    vld1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    to_d    = 1'b0;
    // On a tie the requester not served last time wins.
    win     = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = 8'd0;
        if (m0_req_i || m1_req_i) begin
          grant_d = win;
          addr_d  = win ? m1_addr_i : m0_addr_i;
          req_d   = 1'b1;
          state_d = ARB_WRDY;
        end
      end
      ARB_WRDY: begin
        if (imem_ready_i) begin
          req_d   = 1'b0;
          rdy0_d  = ~grant_q;
          rdy1_d  = grant_q;
          cnt_d   = 8'd0;
          state_d = ARB_WVLD;
        end else if (cnt_q == Lim) begin
          req_d   = 1'b0;
          to_d    = 1'b1;
          last_d  = grant_q;
          cnt_d   = 8'd0;
          state_d = ARB_IDLE;
        end
      end
      ARB_WVLD: begin
        if (imem_valid_i) begin
          if (grant_q) begin
            vld1_d = 1'b1;
            rd1_d  = imem_rdata_i;
          end else begin
            vld0_d = 1'b1;
            rd0_d  = imem_rdata_i;
          end
          last_d  = grant_q;
          cnt_d   = 8'd0;
          state_d = ARB_IDLE;
        end else if (cnt_q == Lim) begin
          to_d    = 1'b1;
          last_d  = grant_q;
          cnt_d   = 8'd0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        req_d   = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign m0_ready_o  = rdy0_q;
  assign m1_ready_o  = rdy1_q;
  assign m0_valid_o  = vld0_q;
  assign m1_valid_o  = vld1_q;
  assign m0_rdata_o  = rd0_q;
  assign m1_rdata_o  = rd1_q;
  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign busy_o      = busy_q;
  assign grant_o     = grant_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_beta_imem_arbiter.sv
// tb_beta_imem_arbiter: directed stimulus with a queue-based scoreboard
// for beta_imem_arbiter; monitor pops on every ready/valid/timeout pulse.
module tb_beta_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_ready_o, m1_ready_o, m0_valid_o, m1_valid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        imem_req_o, imem_ready_i, imem_valid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        busy_o, grant_o, timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } cpl_t;

  typedef struct {
    int          who;
    logic [31:0] addr;
  } rdy_t;

  cpl_t        exp_q[$];
  rdy_t        rdy_q[$];
  cpl_t        ce;
  rdy_t        re;
  int          akind;
  int          awho;
  logic [31:0] adata;
  logic [31:0] sh0, sh1;

  beta_imem_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .m0_req_i     (m0_req_i),
    .m0_addr_i    (m0_addr_i),
    .m0_ready_o   (m0_ready_o),
    .m0_valid_o   (m0_valid_o),
    .m0_rdata_o   (m0_rdata_o),
    .m1_req_i     (m1_req_i),
    .m1_addr_i    (m1_addr_i),
    .m1_ready_o   (m1_ready_o),
    .m1_valid_o   (m1_valid_o),
    .m1_rdata_o   (m1_rdata_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_valid_i (imem_valid_i),
    .imem_rdata_i (imem_rdata_i),
    .busy_o       (busy_o),
    .grant_o      (grant_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: one completion event and one ready event at most per cycle.
  always @(negedge clk) begin
    if (rst) begin
      sh0 = '0;
      sh1 = '0;
    end else begin
      if ((32'(m0_valid_o) + 32'(m1_valid_o) + 32'(timeout_o)) > 1) begin
        chk("multi_cpl", {m0_valid_o, m1_valid_o, timeout_o}, 32'd0);
      end
      if (m0_valid_o || m1_valid_o || timeout_o) begin
        akind = m0_valid_o ? 0 : (m1_valid_o ? 1 : 2);
        adata = m0_valid_o ? m0_rdata_o : (m1_valid_o ? m1_rdata_o : '0);
        if (exp_q.size() == 0) begin
          chk("cpl_unexpected", 32'(akind), 32'hFFFF_FFFF);
        end else begin
          ce = exp_q.pop_front();
          chk("cpl_kind", 32'(akind), 32'(ce.kind));
          chk("cpl_data", adata, ce.data);
          if (ce.kind == 0) sh0 = ce.data;
          if (ce.kind == 1) sh1 = ce.data;
        end
        chk("hold_rdata0", m0_rdata_o, sh0);
        chk("hold_rdata1", m1_rdata_o, sh1);
      end
      if (m0_ready_o && m1_ready_o) begin
        chk("multi_rdy", 32'd2, 32'd1);
      end
      if (m0_ready_o || m1_ready_o) begin
        awho = m0_ready_o ? 0 : 1;
        if (rdy_q.size() == 0) begin
          chk("rdy_unexpected", 32'(awho), 32'hFFFF_FFFF);
        end else begin
          re = rdy_q.pop_front();
          chk("rdy_who", 32'(awho), 32'(re.who));
          chk("rdy_addr", imem_addr_o, re.addr);
        end
      end
    end
  end

  task automatic expect_x(input int who, input logic [31:0] addr,
                          input logic [31:0] data, input bit to);
    rdy_t r;
    cpl_t c;
    r.who  = who;
    r.addr = addr;
    c.kind = to ? 2 : who;
    c.data = to ? 32'd0 : data;
    rdy_q.push_back(r);
    exp_q.push_back(c);
  endtask

  task automatic wait_req(output bit ok);
    int k = 0;
    while (!imem_req_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = imem_req_o;
    if (!ok) chk("wait_imem_req", 32'(imem_req_o), 32'd1);
  endtask

  // Memory model: ready after rdly cycles, valid vdly cycles after ready.
  task automatic serve(input int who, input logic [31:0] d, input int rdly,
                       input int vdly, input bit give_v);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    repeat (rdly) @(negedge clk);
    imem_ready_i = 1'b1;
    @(negedge clk);
    imem_ready_i = 1'b0;
    if (who == 0) m0_req_i = 1'b0;
    else m1_req_i = 1'b0;
    if (!give_v) return;
    repeat (vdly) @(negedge clk);
    imem_valid_i = 1'b1;
    imem_rdata_i = d;
    @(negedge clk);
    imem_valid_i = 1'b0;
    imem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int k;
    bit ok;
    rst          = 1'b1;
    m0_req_i     = 1'b0;
    m1_req_i     = 1'b0;
    m0_addr_i    = '0;
    m1_addr_i    = '0;
    imem_ready_i = 1'b0;
    imem_valid_i = 1'b0;
    imem_rdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    chk("rst_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    chk("rst_pulses",
        {m0_ready_o, m1_ready_o, m0_valid_o, m1_valid_o, timeout_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // m0 alone, ideal memory
    expect_x(0, 32'h100, 32'hDEADBEEF, 0);
    m0_addr_i = 32'h100;
    m0_req_i  = 1'b1;
    @(negedge clk);
    chk("t1_req_lat", 32'(imem_req_o), 32'd1);
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_grant", 32'(grant_o), 32'd0);
    serve(0, 32'hDEADBEEF, 0, 0, 1);
    repeat (2) @(negedge clk);

    // ties after reset: m0, m1, then m0, m1 again
    do_reset();
    chk("t2_rdata_rst", m0_rdata_o, 32'd0);
    for (int i = 0; i < 2; i++) begin
      expect_x(0, 32'h10 + 32'(i * 4), 32'h1111_0000 + 32'(i), 0);
      expect_x(1, 32'h20 + 32'(i * 4), 32'h2222_0000 + 32'(i), 0);
      m0_addr_i = 32'h10 + 32'(i * 4);
      m1_addr_i = 32'h20 + 32'(i * 4);
      m0_req_i  = 1'b1;
      m1_req_i  = 1'b1;
      serve(0, 32'h1111_0000 + 32'(i), 0, 0, 1);
      chk("t2_idle_gap", 32'(imem_req_o), 32'd0);
      @(negedge clk);
      chk("t2_b2b_req", 32'(imem_req_o), 32'd1);
      chk("t2_b2b_grant", 32'(grant_o), 32'd1);
      serve(1, 32'h2222_0000 + 32'(i), 0, 1, 1);
      @(negedge clk);
    end

    // m1 with no valid from memory: abort in the data wait state
    expect_x(1, 32'h30, 32'd0, 1);
    m1_addr_i = 32'h30;
    m1_req_i  = 1'b1;
    serve(1, 32'd0, 0, 0, 0);
    k = 0;
    while (!timeout_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t3_to_lat", 32'(k), 32'd16);
    chk("t3_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("t3_to_pulse", 32'(timeout_o), 32'd0);

    // valid arriving on the exact timeout cycle wins
    expect_x(0, 32'h44, 32'h0000_0013, 0);
    m0_addr_i = 32'h44;
    m0_req_i  = 1'b1;
    serve(0, 32'h0000_0013, 0, 15, 1);
    chk("t4_no_to", 32'(timeout_o), 32'd0);
    repeat (3) @(negedge clk);

    // requester drops req after grant; slow ready and valid
    expect_x(1, 32'h58, 32'h5A5A_0001, 0);
    m1_addr_i = 32'h58;
    m1_req_i  = 1'b1;
    @(negedge clk);
    m1_req_i  = 1'b0;
    serve(1, 32'h5A5A_0001, 3, 2, 1);
    repeat (2) @(negedge clk);

    // async reset while waiting for ready
    m0_addr_i = 32'h60;
    m0_req_i  = 1'b1;
    wait_req(ok);
    @(negedge clk);
    rst          = 1'b1;
    imem_ready_i = 1'b1;
    m0_req_i     = 1'b0;
    #1;
    chk("t6_async_req", 32'(imem_req_o), 32'd0);
    chk("t6_async_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    imem_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    imem_valid_i = 1'b1;
    imem_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_valid_i = 1'b0;
    imem_rdata_i = '0;
    chk("t6_late_vld_busy", 32'(busy_o), 32'd0);
    chk("t6_rdata_clr", m0_rdata_o, 32'd0);
    expect_x(0, 32'h70, 32'hCAFE_F00D, 0);
    m0_addr_i = 32'h70;
    m0_req_i  = 1'b1;
    serve(0, 32'hCAFE_F00D, 0, 0, 1);

    repeat (5) @(negedge clk);
    chk("cpl_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rdy_q_empty", 32'(rdy_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
